fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Program-counter and fetch sequencer sitting directly upstream of the instruction ROM: drives the 16-bit PC that indexes the ROM and watches the returned 9-bit instruction for the halt code.
- Sequences start-up (load start address), normal increment, absolute and relative taken branches, and halt.
- Reports Done to the testbench/top level and counts executed cycles for performance reporting.

Parameters:
- PW, 16, program counter width (matches ROM address width).
- IW, 9, instruction width.
- HALT_CODE, 9'b111_111_111, instruction value that terminates the program.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  one clock; reset is asynchronous and active-low.
- Start  input  1  level request: high holds the block in load, falling to low begins execution.
- StartAddr  input  PW  first instruction address, sampled while in LOAD.
- Inst  input  IW  instruction currently read from the ROM at PC (combinational from ROM).
- BranchAbs  input  1  decoder flags current instruction as absolute branch.
- BranchRel  input  1  decoder flags current instruction as PC-relative branch.
- Taken  input  1  branch condition true (from ALU/zero flag).
- Target  input  PW  absolute target, or two's-complement offset for relative branch.
- PC  output  PW  program counter to ROM.
- Running  output  1  high while in RUN.
- Done  output  1  high while in HALT.
- CycleCt  output  16  count of RUN cycles since last LOAD, saturating.

Behaviour:
- States: IDLE, LOAD, RUN, HALT. Reset_n low (any time, asynchronously): state=IDLE, PC=0, Running=0, Done=0, CycleCt=0.
- IDLE: PC holds. Start=1 -> LOAD next edge.
- LOAD: every edge PC <= StartAddr, CycleCt <= 0. Remains while Start=1; Start=0 -> RUN (PC keeps last loaded StartAddr).
- RUN: Running=1. Each edge, priority order:
  1. Start=1 -> LOAD (abort; PC <= StartAddr on that edge).
  2. Inst==HALT_CODE -> HALT, PC holds (points at the halt instruction).
  3. BranchAbs & Taken -> PC <= Target (wins if BranchRel also high).
  4. BranchRel & Taken -> PC <= PC + Target, signed, modulo 2^PW.
  5. else PC <= PC + 1, modulo 2^PW (0xFFFF -> 0x0000).
  - CycleCt increments on every RUN edge, including the edge that enters HALT; saturates at 0xFFFF.
- Branch flags with Taken=0 behave as case 5. Branch flags and Taken are ignored outside RUN.
- HALT: Done=1, Running=0, PC and CycleCt hold. Start=1 -> LOAD (Done drops on that edge).
- Outputs are registered or pure state decodes; no combinational path from any input to PC/Done/Running.
- Latency: PC changes one edge after the controlling inputs. The instruction at PC is consumed the same cycle it is presented.

Test Plan:
- Reset mid-RUN at PC=0x0007: assert Reset_n=0 between edges -> PC=0, Running=0, Done=0, CycleCt=0 immediately, no clock needed; state IDLE.
- Start=1 for 3 cycles with StartAddr=0x0010, then Start=0; ROM returns non-halt, no branches -> PC sequence 0x10,0x11,0x12,0x13; Running=1; CycleCt=3 after 3 RUN edges.
- At PC=0x0020 BranchRel=1, Taken=1, Target=0xFFFD -> next PC=0x001D. At PC=0x0020 BranchAbs=1 and BranchRel=1, Taken=1, Target=0x0040 -> PC=0x0040. With Taken=0 -> PC=0x0021.
- Wrap: PC=0xFFFF, no branch -> PC=0x0000. PC=0xFFFE, BranchRel taken, Target=0x0003 -> PC=0x0001.
- Inst=9'h1FF at PC=0x0009 with BranchAbs taken, Target=0x0000 also asserted -> HALT, PC stays 0x0009, Done=1, Running=0; CycleCt frozen. Then Start=1 with StartAddr=0 -> LOAD, Done=0, CycleCt=0.
- Start pulsed high for one cycle during RUN at PC=0x0030, StartAddr=0x0005 -> LOAD; PC=0x0005; RUN resumes from 0x0005 after Start falls.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program-counter and fetch sequencer in front of the instruction ROM.
// Handles start-up load, sequential fetch, absolute/relative branches, halt detection and cycle counting.
module fetch_ctrl #(
  parameter int             PW        = 16,
  parameter int             IW        = 9,
  parameter logic [IW-1:0]  HALT_CODE = 9'b111_111_111
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [PW-1:0] StartAddr,
  input  logic [IW-1:0] Inst,
  input  logic          BranchAbs,
  input  logic          BranchRel,
  input  logic          Taken,
  input  logic [PW-1:0] Target,
  output logic [PW-1:0] PC,
  output logic          Running,
  output logic          Done,
  output logic [15:0]   CycleCt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pc_q, pc_nxt;
  logic [15:0]   cyc_q, cyc_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Relative branch: offset is two's complement, result wraps modulo 2^PW.
  function automatic logic [PW-1:0] rel_target(input logic [PW-1:0] base,
                                                input logic signed [PW-1:0] off);
    logic signed [PW-1:0] sum;
    sum = $signed(base) + off;
    return $unsigned(sum);
  endfunction

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cyc_nxt   = cyc_q;
    case (state)
      S_IDLE: begin
        if (Start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        pc_nxt  = StartAddr;
        cyc_nxt = 16'd0;
        if (!Start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (Start) begin
          state_nxt = S_LOAD;
          pc_nxt    = StartAddr;
          cyc_nxt   = 16'd0;
        end else begin
          cyc_nxt = sat_inc(cyc_q);
          if (Inst == HALT_CODE)           state_nxt = S_HALT;
          else if (BranchAbs && Taken)     pc_nxt    = Target;
          else if (BranchRel && Taken)     pc_nxt    = rel_target(pc_q, $signed(Target));
          else                             pc_nxt    = pc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      S_HALT: begin
        if (Start) begin
          state_nxt = S_LOAD;
          pc_nxt    = StartAddr;
          cyc_nxt   = 16'd0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
      pc_q  <= '0;
      cyc_q <= 16'd0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      cyc_q <= cyc_nxt;
    end
  end

  assign PC      = pc_q;
  assign Running = (state == S_RUN);
  assign Done    = (state == S_HALT);
  assign CycleCt = cyc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_ctrl;

  logic        CLK;
  logic        Reset_n;
  logic        Start;
  logic [15:0] StartAddr;
  logic [8:0]  Inst;
  logic        BranchAbs;
  logic        BranchRel;
  logic        Taken;
  logic [15:0] Target;
  logic [15:0] PC;
  logic        Running;
  logic        Done;
  logic [15:0] CycleCt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the sequencer is doing, expressed as flags and plain integers.
  bit          m_loading, m_running, m_halted;
  logic [15:0] m_pc;
  int          m_cycles;

  fetch_ctrl dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Inst(Inst), .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Taken(Taken),
    .Target(Target), .PC(PC), .Running(Running), .Done(Done), .CycleCt(CycleCt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_halted = 0; m_pc = 16'h0000; m_cycles = 0;
  endtask

  task automatic model_edge();
    if (m_loading) begin
      m_pc = StartAddr; m_cycles = 0;
      if (!Start) begin m_loading = 0; m_running = 1; end
    end else if (m_running) begin
      if (Start) begin
        m_running = 0; m_loading = 1; m_pc = StartAddr; m_cycles = 0;
      end else begin
        if (m_cycles < 65535) m_cycles = m_cycles + 1;
        if (Inst == 9'h1FF) begin
          m_running = 0; m_halted = 1;
        end else if (BranchAbs && Taken) begin
          m_pc = Target;
        end else if (BranchRel && Taken) begin
          m_pc = 16'((int'(m_pc) + int'(Target)) % 65536);
        end else begin
          m_pc = 16'((int'(m_pc) + 1) % 65536);
        end
      end
    end else if (m_halted) begin
      if (Start) begin m_halted = 0; m_loading = 1; m_pc = StartAddr; m_cycles = 0; end
    end else begin
      if (Start) m_loading = 1;
    end
  endtask

  task automatic check_model(input string tag);
    checks++;
    assert (PC === m_pc) else begin
      errors++; $error("FAIL %s PC got %h want %h", tag, PC, m_pc);
    end
    checks++;
    assert (Running === m_running) else begin
      errors++; $error("FAIL %s Running got %b want %b", tag, Running, m_running);
    end
    checks++;
    assert (Done === m_halted) else begin
      errors++; $error("FAIL %s Done got %b want %b", tag, Done, m_halted);
    end
    checks++;
    assert (CycleCt === 16'(m_cycles)) else begin
      errors++; $error("FAIL %s CycleCt got %h want %h", tag, CycleCt, 16'(m_cycles));
    end
  endtask

  task automatic expect_pc(input string tag, input logic [15:0] want);
    checks++;
    assert (PC === want) else begin
      errors++; $error("FAIL %s PC got %h want %h", tag, PC, want);
    end
  endtask

  task automatic expect_flags(input string tag, input logic run, input logic dn, input logic [15:0] cyc);
    checks++;
    assert ({Running, Done, CycleCt} === {run, dn, cyc}) else begin
      errors++; $error("FAIL %s run/done/cyc got %b/%b/%h want %b/%b/%h",
                       tag, Running, Done, CycleCt, run, dn, cyc);
    end
  endtask

  task automatic step(input string tag, input bit do_check = 1);
    @(posedge CLK);
    model_edge();
    #1;
    if (do_check) check_model(tag);
  endtask

  task automatic quiet_inputs();
    Start = 0; Inst = 9'h000; BranchAbs = 0; BranchRel = 0; Taken = 0; Target = 16'h0000;
  endtask

  task automatic load_to(input logic [15:0] addr);
    quiet_inputs();
    StartAddr = addr;
    Start = 1;
    step("load_a");
    step("load_b");
    Start = 0;
    step("load_c");
  endtask

  initial begin
    quiet_inputs();
    StartAddr = 16'h0000;
    Reset_n   = 1'b0;
    model_reset();
    #1;
    check_model("reset_init");
    expect_flags("reset_init_c", 1'b0, 1'b0, 16'h0000);
    @(negedge CLK);
    Reset_n = 1'b1;

    // Start-up: Start held three cycles, then sequential fetch
    @(posedge CLK); #1;
    StartAddr = 16'h0010;
    Start = 1;
    step("st1"); step("st2"); step("st3");
    Start = 0;
    step("st_run");
    expect_pc("seq0", 16'h0010);
    step("seq"); expect_pc("seq1", 16'h0011);
    step("seq"); expect_pc("seq2", 16'h0012);
    step("seq"); expect_pc("seq3", 16'h0013);
    expect_flags("seq_cyc", 1'b1, 1'b0, 16'd3);

    // Branches from 0x0020
    load_to(16'h0020);
    BranchRel = 1; Taken = 1; Target = 16'hFFFD;
    step("rel_back"); expect_pc("rel_back_c", 16'h001D);
    load_to(16'h0020);
    BranchAbs = 1; BranchRel = 1; Taken = 1; Target = 16'h0040;
    step("abs_wins"); expect_pc("abs_wins_c", 16'h0040);
    load_to(16'h0020);
    BranchAbs = 1; BranchRel = 1; Taken = 0; Target = 16'h0040;
    step("not_taken"); expect_pc("not_taken_c", 16'h0021);

    // Wrap-around
    load_to(16'hFFFF);
    step("wrap_inc"); expect_pc("wrap_inc_c", 16'h0000);
    load_to(16'hFFFE);
    BranchRel = 1; Taken = 1; Target = 16'h0003;
    step("wrap_rel"); expect_pc("wrap_rel_c", 16'h0001);

    // Halt beats a simultaneous taken branch
    load_to(16'h0009);
    Inst = 9'h1FF; BranchAbs = 1; Taken = 1; Target = 16'h0000;
    step("halt"); expect_pc("halt_pc", 16'h0009);
    expect_flags("halt_flags", 1'b0, 1'b1, 16'd1);
    for (int i = 0; i < 4; i++) begin
      Inst = 9'($urandom); BranchAbs = 1'($urandom); BranchRel = 1'($urandom);
      Taken = 1'($urandom); Target = 16'($urandom);
      step("halt_hold");
    end
    expect_flags("halt_frozen", 1'b0, 1'b1, 16'd1);
    quiet_inputs();
    StartAddr = 16'h0000; Start = 1;
    step("halt_reload");
    expect_flags("halt_reload_c", 1'b0, 1'b0, 16'd0);

    // One-cycle Start pulse aborts RUN
    load_to(16'h0030);
    StartAddr = 16'h0005; Start = 1;
    step("abort"); expect_pc("abort_pc", 16'h0005);
    Start = 0;
    step("abort_run"); expect_pc("abort_run_pc", 16'h0005);
    step("abort_next"); expect_pc("abort_next_pc", 16'h0006);

    // Asynchronous reset in the middle of a RUN cycle
    load_to(16'h0007);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    expect_flags("async_rst_c", 1'b0, 1'b0, 16'h0000);
    @(negedge CLK);
    Reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Start     = ($urandom_range(0, 19) == 0);
      StartAddr = 16'($urandom);
      Inst      = ($urandom_range(0, 24) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      BranchAbs = ($urandom_range(0, 5) == 0);
      BranchRel = ($urandom_range(0, 4) == 0);
      Taken     = 1'($urandom);
      Target    = 16'($urandom);
      step("rand");
    end

    // Cycle counter saturation
    load_to(16'h0100);
    for (int i = 0; i < 65540; i++) step("sat", 0);
    check_model("sat_model");
    expect_flags("sat_c", 1'b1, 1'b0, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
